ac97_record_rx: RTL and testbench
=================================

AC97_RECORD_RX -- requirements
Module: ac97_record_rx

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 18: width of each output record sample; the legal range is 1..20.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 bit_en  input  1  one-cycle strobe; sync and sdata_in are sampled only on clk edges where bit_en=1.
REQ-005 sync  input  1  AC97 frame sync; high during the 16-bit tag phase.
REQ-006 sdata_in  input  1  AC97 serial data from the codec, MSB first.
REQ-007 record_left  output  SAMPLE_WIDTH  most recent left PCM record sample (slot 3).
REQ-008 record_right  output  SAMPLE_WIDTH  most recent right PCM record sample (slot 4).
REQ-009 record_valid  output  1  one-cycle pulse; record_left and record_right were updated.
REQ-010 codec_ready  output  1  tag bit 15 of the last complete tag phase.
REQ-011 frame_error  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 Frame format: 256 bits = tag (16 bits) + slots 1..12 (20 bits each); bit_cnt runs 0..255.
REQ-013 Frame start: a bit_en sample with sync=1 whose previous bit_en sample had sync=0; that bit is tag bit 15 (bit_cnt=0).
REQ-014 States:
- HUNT: wait for frame start, then go to TAG with bit_cnt=0.
- TAG: bit_cnt 0..15.
- SLOTS: bit_cnt 16..255.
- After bit_cnt=255, return to TAG when the next bit_en is a frame start; otherwise pulse frame_error and go to HUNT.
REQ-015 The tag is shifted in MSB first. Bit 15 = codec ready; bits 14..3 = slot 1..12 valid flags.
REQ-016 codec_ready updates when the tag completes (the bit_en at bit_cnt=15).
REQ-017 Slot 3 occupies bit_cnt 56..75 and slot 4 occupies bit_cnt 76..95. Each is shifted into its own 20-bit register.
REQ-018 Each output sample is the 20-bit slot value, bits [19:20-SAMPLE_WIDTH], truncated with no rounding.
REQ-019 Outputs update only when all of these hold on the bit_en at bit_cnt=95: codec ready=1, slot3 valid=1 and slot4 valid=1 in the current frame's tag.
- When they update, record_valid=1 for exactly the following clk cycle.
- When any condition fails, the outputs hold and no pulse is issued.
REQ-020 record_left and record_right hold their values between updates.
REQ-021 Sync rising (a frame start) while bit_cnt is 1..255:
- pulse frame_error;
- discard the partial frame, with no record_valid for it;
- treat the bit as bit_cnt=0 of a new frame and enter TAG.
REQ-022 Sync low during TAG at bit_cnt 1..15 is a violation:
- pulse frame_error;
- go to HUNT.
REQ-023 Clock cycles with bit_en=0 change no state. The record_valid and frame_error pulses still deassert after one cycle.
REQ-024 record_valid and frame_error are registered outputs, never combinational from the inputs.

Reset
REQ-025 When reset=1, on the next clk edge:
- state=HUNT, bit_cnt=0;
- shift registers cleared;
- record_left=0, record_right=0;
- record_valid=0, codec_ready=0, frame_error=0;
- previous-sync register=0.
REQ-026 Reset has priority over bit_en. A reset mid-frame discards the frame, and the block resynchronises on the next frame start.

Verification
REQ-027 Nominal frame: tag=0xF800 (ready, slots 1-4 valid), slot3=0x12345, slot4=0xABCDE, bit_en every 4 clk -> record_left=0x048D1, record_right=0x2AF37, record_valid high for 1 cycle after the bit_cnt=95 strobe, codec_ready=1.
REQ-028 Slot 4 invalid: tag=0xF000, other data as in REQ-027 -> no record_valid, outputs keep their prior values, codec_ready=1.
REQ-029 Sync rises at bit_cnt=40 of a frame -> frame_error pulse, no record_valid for that frame; the next full frame (REQ-027 data) yields record_valid with 0x048D1/0x2AF37.
REQ-030 Frame ends at bit_cnt=255 with sync still low at the next bit -> frame_error pulse, state HUNT; a later frame start resumes normal decode.
REQ-031 Reset asserted at bit_cnt=80 -> all outputs 0 on the next clk; the following complete frame decodes normally.
REQ-032 Back-to-back 10 frames with incrementing slot3/slot4 values and bit_en every clk -> exactly 10 record_valid pulses, each with matching truncated samples, and no frame_error.

Source files
------------

// File: rtl/ac97_record_rx.sv
// AC97 record-path deserialiser: locks onto frame sync, decodes the tag and
// captures the slot 3/4 PCM record samples into registered outputs.
module ac97_record_rx #(
   parameter int SAMPLE_WIDTH = 18
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    bit_en,
   input  logic                    sync,
   input  logic                    sdata_in,
   output logic [SAMPLE_WIDTH-1:0] record_left,
   output logic [SAMPLE_WIDTH-1:0] record_right,
   output logic                    record_valid,
   output logic                    codec_ready,
   output logic                    frame_error
);

   // state | meaning
   // HUNT  | waiting for a sync rising edge (frame start)
   // TAG   | receiving tag bits 0..15, sync must stay high
   // SLOTS | receiving bits 16..255; cnt wrapping to 0 means a frame start is due
   typedef enum logic [1:0] {HUNT, TAG, SLOTS} state_t;

   state_t                  state_q;
   logic [7:0]              cnt_q;
   logic                    sync_prev_q;
   logic [14:0]             tag_q;
   logic [19:0]             slot3_q;
   logic [19:0]             slot4_q;
   logic                    slot3_vld_q;
   logic                    slot4_vld_q;
   logic                    codec_ready_q;
   logic [SAMPLE_WIDTH-1:0] left_q;
   logic [SAMPLE_WIDTH-1:0] right_q;
   logic                    valid_q;
   logic                    ferr_q;

   logic        frame_start;
   logic [19:0] slot4_full;

   assign frame_start = sync & ~sync_prev_q;
   assign slot4_full  = {slot4_q[18:0], sdata_in};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= HUNT;
         cnt_q         <= 8'd0;
         sync_prev_q   <= 1'b0;
         tag_q         <= '0;
         slot3_q       <= '0;
         slot4_q       <= '0;
         slot3_vld_q   <= 1'b0;
         slot4_vld_q   <= 1'b0;
         codec_ready_q <= 1'b0;
         left_q        <= '0;
         right_q       <= '0;
         valid_q       <= 1'b0;
         ferr_q        <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         if (bit_en) begin
            sync_prev_q <= sync;
            unique case (state_q)
               HUNT: begin
                  if (frame_start) begin
                     state_q <= TAG;
                     cnt_q   <= 8'd1;
                     tag_q   <= {tag_q[13:0], sdata_in};
                  end
               end
               TAG: begin
                  if (!sync) begin
                     ferr_q  <= 1'b1;
                     state_q <= HUNT;
                     cnt_q   <= 8'd0;
                  end else begin
                     tag_q <= {tag_q[13:0], sdata_in};
                     cnt_q <= cnt_q + 8'd1;
                     // tag_q now holds tag bits 15..1; bit b sits at tag_q[b-1]
                     if (cnt_q == 8'd15) begin
                        codec_ready_q <= tag_q[14];
                        slot3_vld_q   <= tag_q[11];
                        slot4_vld_q   <= tag_q[10];
                        state_q       <= SLOTS;
                     end
                  end
               end
               SLOTS: begin
                  if (frame_start) begin
                     ferr_q  <= (cnt_q != 8'd0);
                     state_q <= TAG;
                     cnt_q   <= 8'd1;
                     tag_q   <= {tag_q[13:0], sdata_in};
                  end else if (cnt_q == 8'd0) begin
                     ferr_q  <= 1'b1;
                     state_q <= HUNT;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                     if (cnt_q >= 8'd56 && cnt_q <= 8'd75)
                        slot3_q <= {slot3_q[18:0], sdata_in};
                     if (cnt_q >= 8'd76 && cnt_q <= 8'd95)
                        slot4_q <= slot4_full;
                     if (cnt_q == 8'd95 && codec_ready_q && slot3_vld_q && slot4_vld_q) begin
                        left_q  <= slot3_q[19 -: SAMPLE_WIDTH];
                        right_q <= slot4_full[19 -: SAMPLE_WIDTH];
                        valid_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= HUNT;
                  cnt_q   <= 8'd0;
               end
            endcase
         end
      end
   end

   assign record_left  = left_q;
   assign record_right = right_q;
   assign record_valid = valid_q;
   assign codec_ready  = codec_ready_q;
   assign frame_error  = ferr_q;

endmodule

// File: tb/tb_ac97_record_rx.sv
// Directed bench for ac97_record_rx: nominal decode, invalid slot, framing
// errors, mid-frame reset and back-to-back frames.
module tb_ac97_record_rx;
   localparam int SW = 18;

   logic          clk = 1'b0;
   logic          reset;
   logic          bit_en;
   logic          sync;
   logic          sdata_in;
   logic [SW-1:0] record_left;
   logic [SW-1:0] record_right;
   logic          record_valid;
   logic          codec_ready;
   logic          frame_error;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int rv_cnt = 0;
   int fe_cnt = 0;
   int rv_run = 0;
   int rv_max = 0;
   int rv_cyc = -1;
   int bit95_cyc = -2;

   ac97_record_rx #(.SAMPLE_WIDTH(SW)) dut (
      .clk          (clk),
      .reset        (reset),
      .bit_en       (bit_en),
      .sync         (sync),
      .sdata_in     (sdata_in),
      .record_left  (record_left),
      .record_right (record_right),
      .record_valid (record_valid),
      .codec_ready  (codec_ready),
      .frame_error  (frame_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (record_valid) begin
         rv_cnt = rv_cnt + 1;
         rv_run = rv_run + 1;
         if (rv_run > rv_max) rv_max = rv_run;
         rv_cyc = cyc;
      end else begin
         rv_run = 0;
      end
      if (frame_error) fe_cnt = fe_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mk_frame(input logic [15:0] tag, input logic [19:0] s3,
                                             input logic [19:0] s4);
      logic [255:0] f;
      f = '0;
      f[255 -: 16] = tag;
      f[199 -: 20] = s3;
      f[179 -: 20] = s4;
      return f;
   endfunction

   function automatic logic [31:0] tr(input logic [19:0] v);
      return 32'(v >> (20 - SW));
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_one(input logic s, input logic d, input int gap);
      sync     = s;
      sdata_in = d;
      bit_en   = 1'b1;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
      if (gap > 1) idle(gap - 1);
   endtask

   task automatic send_bits(input logic [255:0] f, input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) begin
         send_one(i < 16, f[255-i], gap);
         if (i == 95) bit95_cyc = cyc - ((gap > 1) ? gap - 1 : 0);
      end
   endtask

   initial begin
      int rv0, fe0;
      logic [255:0] f;
      logic [19:0] s3, s4;

      reset = 1'b1; bit_en = 1'b0; sync = 1'b0; sdata_in = 1'b0;
      idle(3);
      reset = 1'b0;
      chk("rst_left", 32'(record_left), 32'h0);
      chk("rst_right", 32'(record_right), 32'h0);
      chk("rst_valid", 32'(record_valid), 32'h0);
      chk("rst_ready", 32'(codec_ready), 32'h0);
      chk("rst_ferr", 32'(frame_error), 32'h0);

      // nominal frame, bit_en every 4 clk
      rv0 = rv_cnt; fe0 = fe_cnt;
      send_bits(mk_frame(16'hF800, 20'h12345, 20'hABCDE), 0, 255, 4);
      idle(2);
      chk("nom_rv_count", 32'(rv_cnt - rv0), 32'd1);
      chk("nom_rv_width", 32'(rv_max), 32'd1);
      chk("nom_rv_timing", 32'(rv_cyc), 32'(bit95_cyc));
      chk("nom_left", 32'(record_left), 32'h048D1);
      chk("nom_right", 32'(record_right), 32'h2AF37);
      chk("nom_ready", 32'(codec_ready), 32'h1);
      chk("nom_ferr", 32'(fe_cnt - fe0), 32'd0);

      // slot 4 invalid: outputs hold
      rv0 = rv_cnt; fe0 = fe_cnt;
      send_bits(mk_frame(16'hF000, 20'h11111, 20'h22222), 0, 255, 2);
      idle(2);
      chk("s4inv_rv_count", 32'(rv_cnt - rv0), 32'd0);
      chk("s4inv_left", 32'(record_left), 32'h048D1);
      chk("s4inv_right", 32'(record_right), 32'h2AF37);
      chk("s4inv_ready", 32'(codec_ready), 32'h1);
      chk("s4inv_ferr", 32'(fe_cnt - fe0), 32'd0);

      // sync rises at bit 40 of a frame
      rv0 = rv_cnt; fe0 = fe_cnt;
      send_bits(mk_frame(16'hF800, 20'h11111, 20'h22222), 0, 39, 1);
      send_bits(mk_frame(16'hF800, 20'h12345, 20'hABCDE), 0, 255, 1);
      idle(2);
      chk("early_ferr", 32'(fe_cnt - fe0), 32'd1);
      chk("early_rv_count", 32'(rv_cnt - rv0), 32'd1);
      chk("early_left", 32'(record_left), 32'h048D1);
      chk("early_right", 32'(record_right), 32'h2AF37);

      // no frame start after bit 255, then resume
      fe0 = fe_cnt;
      send_one(1'b0, 1'b0, 1);
      idle(2);
      chk("late_ferr", 32'(fe_cnt - fe0), 32'd1);
      rv0 = rv_cnt; fe0 = fe_cnt;
      send_bits(mk_frame(16'hF800, 20'h0FFFF, 20'hFFFFF), 0, 255, 1);
      idle(2);
      chk("late_rv_count", 32'(rv_cnt - rv0), 32'd1);
      chk("late_left", 32'(record_left), 32'h03FFF);
      chk("late_right", 32'(record_right), 32'h3FFFF);
      chk("late_ferr_none", 32'(fe_cnt - fe0), 32'd0);

      // sync drops inside the tag
      rv0 = rv_cnt; fe0 = fe_cnt;
      f = mk_frame(16'hF800, 20'h55555, 20'h66666);
      send_bits(f, 0, 4, 1);
      send_one(1'b0, 1'b0, 1);
      idle(2);
      chk("tag_ferr", 32'(fe_cnt - fe0), 32'd1);
      send_bits(mk_frame(16'hF800, 20'h12345, 20'hABCDE), 0, 255, 1);
      idle(2);
      chk("tag_rv_count", 32'(rv_cnt - rv0), 32'd1);
      chk("tag_left", 32'(record_left), 32'h048D1);

      // reset at bit 80
      send_bits(mk_frame(16'hF800, 20'h77777, 20'h88888), 0, 80, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mrst_left", 32'(record_left), 32'h0);
      chk("mrst_right", 32'(record_right), 32'h0);
      chk("mrst_ready", 32'(codec_ready), 32'h0);
      chk("mrst_valid", 32'(record_valid), 32'h0);
      chk("mrst_ferr", 32'(frame_error), 32'h0);
      rv0 = rv_cnt;
      send_bits(mk_frame(16'hF800, 20'h12345, 20'hABCDE), 0, 255, 1);
      idle(2);
      chk("mrst_rv_count", 32'(rv_cnt - rv0), 32'd1);
      chk("mrst_left_after", 32'(record_left), 32'h048D1);
      chk("mrst_right_after", 32'(record_right), 32'h2AF37);

      // ten back-to-back frames, bit_en every clk
      rv0 = rv_cnt; fe0 = fe_cnt;
      for (int k = 0; k < 10; k++) begin
         s3 = 20'h12345 + 20'(k * 4);
         s4 = 20'hABCDE + 20'(k * 8);
         send_bits(mk_frame(16'hF800, s3, s4), 0, 255, 1);
         chk($sformatf("b2b_left_%0d", k), 32'(record_left), tr(s3));
         chk($sformatf("b2b_right_%0d", k), 32'(record_right), tr(s4));
      end
      idle(2);
      chk("b2b_rv_count", 32'(rv_cnt - rv0), 32'd10);
      chk("b2b_ferr", 32'(fe_cnt - fe0), 32'd0);
      chk("rv_width_all", 32'(rv_max), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
